// File: rtl/mips16_multicycle_ctrl.sv
// Multicycle control FSM for the 16-bit MIPS datapath: sequences fetch/decode/execute
// and decodes ALU control, datapath enables and mux selects from the state register.
module mips16_multicycle_ctrl #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         opcode,
  input  logic [2:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [2:0]         alu_control,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic               pc_en,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_EXEC   = 4'd6,  S_RWB   = 4'd7,
    S_BRANCH  = 4'd8,  S_JUMP    = 4'd9,  S_ADDI_EX = 4'd10, S_ADDI_WB = 4'd11,
    S_HALT    = 4'd15
  } state_t;

  localparam logic [3:0] OP_R = 4'd0, OP_LW = 4'd1, OP_SW = 4'd2,
                         OP_BEQ = 4'd3, OP_ADDI = 4'd4, OP_J = 4'd5;

  state_t             r_state;
  logic [COUNT_W-1:0] r_count;
  logic               r_illegal;
  logic               w_funct_ok;

  assign w_funct_ok = (funct == 3'd0) || (funct == 3'd1) || (funct == 3'd5) ||
                      (funct == 3'd6) || (funct == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_count   <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) begin
          r_state <= S_DECODE;
          r_count <= r_count + 1'b1;
        end
        S_DECODE: begin
          case (opcode)
            OP_R:         r_state <= w_funct_ok ? S_EXEC : S_HALT;
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDI_EX;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_HALT;
          endcase
          if (!((opcode == OP_R && w_funct_ok) || (opcode >= OP_LW && opcode <= OP_J)))
            r_illegal <= 1'b1;
        end
        // Opcode re-sampled here; anything other than lw/sw falls back to store.
        S_MEMADR:  r_state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   if (mem_ready) r_state <= S_MEMWB;
        S_MEMWR:   if (mem_ready) r_state <= S_FETCH;
        S_EXEC:    r_state <= S_RWB;
        S_ADDI_EX: r_state <= S_ADDI_WB;
        S_HALT:    r_state <= S_HALT;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    alu_control = 3'd0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_source   = 2'b00;
    pc_en       = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE:  alu_src_b = 2'b11;
      S_MEMADR:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEMRD:   begin mem_read = 1'b1; i_or_d = 1'b1; end
      S_MEMWB:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      S_MEMWR:   begin mem_write = 1'b1; i_or_d = 1'b1; end
      S_EXEC:    begin alu_src_a = 1'b1; alu_control = funct; end
      S_RWB:     begin reg_write = 1'b1; reg_dst = 1'b1; end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = 3'd1;
        pc_source   = 2'b01;
        pc_en       = zero;
      end
      S_JUMP:    begin pc_source = 2'b10; pc_en = 1'b1; end
      S_ADDI_EX: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_ADDI_WB: reg_write = 1'b1;
      default: ;
    endcase
  end

  assign illegal     = r_illegal;
  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: doc/mips16_multicycle_ctrl.md
Name: mips16_multicycle_ctrl

Overview:
- Moore-style multicycle control FSM for the 16-bit MIPS datapath.
- Produces the 3-bit ALU control code consumed by the 16-bit ALU, plus all datapath enables and selects.
- Consumes opcode/funct from the instruction register, the ALU zero flag and a memory-ready handshake.
- Sits between the IR/ALU and the PC, register-file, memory and mux controls.

Parameters:
COUNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
opcode  input  4  IR[15:12]
funct  input  3  IR[2:0], R-type ALU function
zero  input  1  ALU Zero flag
mem_ready  input  1  memory access completes this cycle
alu_control  output  3  0 add, 1 sub, 5 and, 6 or, 7 slt
alu_src_a  output  1  0 PC, 1 register A
alu_src_b  output  2  00 reg B, 01 const 1, 10 sign-ext imm6, 11 sign-ext imm6 (branch offset)
pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target
pc_en  output  1  PC load enable
ir_write  output  1  IR load enable
mem_read  output  1  memory read request
mem_write  output  1  memory write request
i_or_d  output  1  0 PC address, 1 ALUOut address
reg_write  output  1  register-file write enable
reg_dst  output  1  0 rt, 1 rd
mem_to_reg  output  1  0 ALUOut, 1 MDR
illegal  output  1  sticky illegal-instruction flag
state  output  4  current state, for debug
instr_count  output  COUNT_W  count of completed fetches

Behaviour:
- Opcodes: 0000 R-type, 0001 lw, 0010 sw, 0011 beq, 0100 addi, 0101 j. All other opcodes are illegal.
- Legal R-type funct values: 0, 1, 5, 6, 7. R-type alu_control equals funct.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, HALT 15. Codes 12-14 are unreachable and go to FETCH.
- Output generation: all outputs decode from the state register only, except ir_write, pc_en (FETCH) and pc_en (BRANCH), as noted below. Any output not listed for a state is 0; alu_control defaults to 000.
- Reset (async, rst_n low): state = FETCH; instr_count = 0; illegal = 0. Other outputs take their FETCH values, with ir_write = pc_en = 0 while mem_ready = 0.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, src_a = 0, src_b = 01, add.
  - ir_write = pc_en = mem_ready.
  - Stays in FETCH while mem_ready = 0.
  - When mem_ready = 1: go to DECODE and increment instr_count (wraps modulo 2^COUNT_W).
- DECODE:
  - Outputs: src_a = 0, src_b = 11, add (branch target precompute).
  - Next state: R-type with legal funct -> EXEC; lw/sw -> MEMADR; beq -> BRANCH; addi -> ADDI_EX; j -> JUMP.
  - Illegal opcode or illegal funct -> HALT.
- MEMADR: src_a = 1, src_b = 10, add. lw -> MEMRD; sw -> MEMWR. Opcode is sampled again here.
- MEMRD: mem_read = 1, i_or_d = 1. Waits for mem_ready, then -> MEMWB.
- MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. -> FETCH.
- MEMWR: mem_write = 1, i_or_d = 1. Waits for mem_ready, then -> FETCH.
- EXEC: src_a = 1, src_b = 00, alu_control = funct. -> RWB.
- RWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. -> FETCH.
- BRANCH: src_a = 1, src_b = 00, sub, pc_source = 01, pc_en = zero (combinational). -> FETCH.
- JUMP: pc_source = 10, pc_en = 1. -> FETCH.
- ADDI_EX: src_a = 1, src_b = 10, add. -> ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. -> FETCH.
- HALT: all enables 0, illegal = 1. Stays in HALT until reset.
- Memory handshake: mem_read/mem_write hold steady for the whole wait. mem_write is never asserted in the same cycle as reg_write.
- Reset asserted mid-instruction returns to FETCH immediately. No write enable may pulse after rst_n falls.

Test Plan:
- Reset with mem_ready = 1 -> state = 0, illegal = 0, instr_count = 0. After rst_n rises: FETCH has ir_write = pc_en = 1, then DECODE.
- R-type, opcode 0, funct 1, mem_ready = 1 -> states 0, 1, 6, 7, 0. EXEC: alu_control = 1, src_b = 00. RWB: reg_write = 1, reg_dst = 1. instr_count = 1.
- lw, opcode 1, mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_read = i_or_d = 1. MEMWB: reg_write = 1, mem_to_reg = 1.
- beq, opcode 3: zero = 1 -> pc_en = 1, pc_source = 01, alu_control = 1 in BRANCH. Repeat with zero = 0 -> pc_en = 0.
- Opcode 1111 -> DECODE then HALT, illegal = 1, held 20 cycles with all enables 0. Pulse rst_n -> FETCH, illegal = 0.
- Drop rst_n during MEMWR (sw, mem_ready = 0) -> mem_write falls in the same cycle. state = 0; instr_count resets to 0.
